// File: rtl/nios2_debug_cmd_sysclk_queue_if.sv
// nios2_debug_cmd_sysclk_queue_if
//   Signal bundle between the JTAG-side producer / CPU-side consumer and the
//   system-clock debug command queue.
//   master : drives the JTAG strobes, IR/DR values, cmd_ready and clr_overflow;
//            observes the queue outputs.
//   slave  : the queue itself.
//   Signals: ir_in, sr, vs_udr, vs_uir, cmd_ready, clr_overflow (to queue);
//            cmd_valid, cur_ir, jdo, take_action, take_no_action, fifo_level,
//            overflow (from queue).
interface nios2_debug_cmd_sysclk_queue_if #(
    parameter int DR_W  = 38,
    parameter int IR_W  = 2,
    parameter int DEPTH = 4
);
    localparam int NCH   = 2 ** IR_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [IR_W-1:0]  ir_in;
    logic [DR_W-1:0]  sr;
    logic             vs_udr;
    logic             vs_uir;
    logic             cmd_ready;
    logic             clr_overflow;
    logic             cmd_valid;
    logic [IR_W-1:0]  cur_ir;
    logic [DR_W-1:0]  jdo;
    logic [NCH-1:0]   take_action;
    logic [NCH-1:0]   take_no_action;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

    modport master (
        output ir_in, sr, vs_udr, vs_uir, cmd_ready, clr_overflow,
        input  cmd_valid, cur_ir, jdo, take_action, take_no_action, fifo_level, overflow
    );

    modport slave (
        input  ir_in, sr, vs_udr, vs_uir, cmd_ready, clr_overflow,
        output cmd_valid, cur_ir, jdo, take_action, take_no_action, fifo_level, overflow
    );
endinterface

// File: rtl/nios2_debug_cmd_sysclk_queue.sv
// nios2_debug_cmd_sysclk_queue
//   System-clock half of the JTAG debug slave. Synchronises and edge-detects
//   the virtual-JTAG update-DR / update-IR strobes, queues every updated
//   {ir, sr} pair in a DEPTH-entry FIFO and pops entries under valid/ready.
//   Each pop yields a registered jdo plus one take_action / take_no_action
//   pulse indexed by the entry's IR code.
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset
//     bus      slave modport of nios2_debug_cmd_sysclk_queue_if
module nios2_debug_cmd_sysclk_queue #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 34
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nios2_debug_cmd_sysclk_queue_if.slave bus
);
    localparam int NCH   = 2 ** IR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // ---- strobe synchronisers and edge detectors ----
    // vld_p shifts ones in after reset; once its last stage is set the sync
    // chains hold genuinely sampled values, so arming cannot be triggered by
    // the chains' own reset zeros.
    logic [SYNC_STAGES-1:0] vld_p;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_prev, uir_prev;
    logic                   udr_armed, uir_armed;
    logic                   upd_dr, upd_ir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p     <= '0;
            udr_sync  <= '0;
            uir_sync  <= '0;
            udr_prev  <= 1'b0;
            uir_prev  <= 1'b0;
            udr_armed <= 1'b0;
            uir_armed <= 1'b0;
            upd_dr    <= 1'b0;
            upd_ir    <= 1'b0;
        end else begin
            vld_p    <= {vld_p[SYNC_STAGES-2:0], 1'b1};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
            udr_prev <= udr_sync[SYNC_STAGES-1];
            uir_prev <= uir_sync[SYNC_STAGES-1];
            if (vld_p[SYNC_STAGES-1] && !udr_sync[SYNC_STAGES-1]) udr_armed <= 1'b1;
            if (vld_p[SYNC_STAGES-1] && !uir_sync[SYNC_STAGES-1]) uir_armed <= 1'b1;
            upd_dr <= udr_armed & udr_sync[SYNC_STAGES-1] & ~udr_prev;
            upd_ir <= uir_armed & uir_sync[SYNC_STAGES-1] & ~uir_prev;
        end
    end

    // ---- command FIFO and pop outputs ----
    logic [IR_W-1:0]  mem_ir [DEPTH];
    logic [DR_W-1:0]  mem_sr [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level, level_nxt;
    logic             cmd_valid_q;
    logic             overflow_q;
    logic [IR_W-1:0]  cur_ir_q;
    logic [DR_W-1:0]  jdo_q;
    logic [NCH-1:0]   take_act_q, take_no_act_q;

    logic             full, push, pop, drop;
    logic [DR_W-1:0]  head_sr;
    logic [NCH-1:0]   head_sel;

    always_comb begin
        full     = (level == LVL_W'(DEPTH));
        pop      = cmd_valid_q & bus.cmd_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push     = upd_dr & (~full | pop);
        drop     = upd_dr & full & ~pop;
        head_sr  = mem_sr[rd_ptr];
        head_sel = NCH'(1) << mem_ir[rd_ptr];
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + LVL_W'(1);
        else if (pop && !push)
            level_nxt = level - LVL_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_ir[i] <= '0;
                mem_sr[i] <= '0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            cmd_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
            cur_ir_q      <= '0;
            jdo_q         <= '0;
            take_act_q    <= '0;
            take_no_act_q <= '0;
        end else begin
            level       <= level_nxt;
            cmd_valid_q <= (level_nxt != '0);

            if (upd_ir)
                cur_ir_q <= bus.ir_in;

            if (push) begin
                mem_ir[wr_ptr] <= bus.ir_in;
                mem_sr[wr_ptr] <= bus.sr;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                jdo_q  <= head_sr;
            end
            take_act_q    <= (pop &&  head_sr[ACT_BIT]) ? head_sel : '0;
            take_no_act_q <= (pop && !head_sr[ACT_BIT]) ? head_sel : '0;

            // A coincident drop beats the clear.
            if (drop)
                overflow_q <= 1'b1;
            else if (bus.clr_overflow)
                overflow_q <= 1'b0;
        end
    end

    assign bus.cmd_valid      = cmd_valid_q;
    assign bus.cur_ir         = cur_ir_q;
    assign bus.jdo            = jdo_q;
    assign bus.take_action    = take_act_q;
    assign bus.take_no_action = take_no_act_q;
    assign bus.fifo_level     = level;
    assign bus.overflow       = overflow_q;
endmodule
